perturbation_irq_ctrl: RTL and testbench

//  Testbench interrupt scheduler for the core perturbation environment. Selects the irq stimulus

---
 rtl/perturbation_irq_ctrl.sv | 136 +++++++++++++
 tb/tb_perturbation_irq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/perturbation_irq_ctrl.sv
// perturbation_irq_ctrl: sequences one irq at a time to the core (delay -> assert -> wait for ack)
module perturbation_irq_ctrl #(
  parameter int unsigned DLY_W          = 8,
  parameter int unsigned RAND_MIN_DELAY = 4,
  parameter int unsigned IRQ_ID_MIN     = 16,
  parameter int unsigned IRQ_ID_MAX     = 31,
  parameter logic [31:0] LFSR_SEED      = 32'h0000_0001,
  parameter int unsigned ACK_TIMEOUT    = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      mode_i,
  input  logic [31:0]      pc_i,
  input  logic             pc_valid_i,
  input  logic [31:0]      pc_trig_addr_i,
  input  logic [4:0]       pc_trig_id_i,
  input  logic             sw_req_valid_i,
  output logic             sw_req_ready_o,
  input  logic [4:0]       sw_req_id_i,
  input  logic [DLY_W-1:0] sw_req_delay_i,
  output logic             irq_o,
  output logic [4:0]       irq_id_o,
  input  logic             irq_ack_i,
  input  logic [4:0]       irq_ack_id_i,
  output logic             busy_o,
  output logic [31:0]      irq_count_o,
  output logic             timeout_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} state_e;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] M_RANDOM  = 32'd2;
  localparam logic [31:0] M_PC_TRIG = 32'd3;
  localparam logic [31:0] M_SW      = 32'd4;
  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d, rand_cnt;
  logic [4:0]       id_q, id_d, rand_id;
  logic [31:0]      mode_q, mode_d, lfsr_q, lfsr_d, count_q, count_d;
  logic             pc_armed_q, pc_armed_d, pc_hit, ack_ok;
`ifdef PERTURB_IRQ_TIMEOUT_EN
  logic [31:0]      wdog_q, wdog_d;
  logic             timeout_q, timeout_d;
`endif
  assign sw_req_ready_o = (state_q == S_IDLE) && (mode_i == M_SW);
  assign irq_o          = (state_q == S_ASSERT);
  assign irq_id_o       = id_q;
  assign busy_o         = (state_q != S_IDLE);
  assign irq_count_o    = count_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    mode_d     = mode_q;
    count_d    = count_q;
    lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    pc_armed_d = (pc_valid_i && pc_i != pc_trig_addr_i) ? 1'b1 : pc_armed_q;
    pc_hit     = pc_valid_i && (pc_i == pc_trig_addr_i) && pc_armed_q;
    ack_ok     = irq_ack_i && (irq_ack_id_i == id_q);
    rand_cnt   = (lfsr_q[DLY_W-1:0] < DLY_W'(RAND_MIN_DELAY)) ? DLY_W'(RAND_MIN_DELAY) : lfsr_q[DLY_W-1:0];
    rand_id    = (lfsr_q[20:16] < 5'(IRQ_ID_MIN) || lfsr_q[20:16] > 5'(IRQ_ID_MAX)) ? 5'(IRQ_ID_MIN) : lfsr_q[20:16];
`ifdef PERTURB_IRQ_TIMEOUT_EN
    wdog_d     = (state_q == S_ASSERT) ? wdog_q + 32'd1 : 32'd0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mode_i == M_RANDOM) begin
          state_d = S_WAIT;
          cnt_d   = rand_cnt;
          id_d    = rand_id;
          mode_d  = mode_i;
        end else if (mode_i == M_PC_TRIG && pc_hit) begin
          state_d    = S_ASSERT;
          id_d       = pc_trig_id_i;
          pc_armed_d = 1'b0;
          mode_d     = mode_i;
        end else if (mode_i == M_SW && sw_req_valid_i) begin
          state_d = S_WAIT;
          cnt_d   = sw_req_delay_i;
          id_d    = sw_req_id_i;
          mode_d  = mode_i;
        end
      end
      S_WAIT: begin
        if (mode_i != mode_q) state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_ASSERT;
        else cnt_d = cnt_q - DLY_W'(1);
      end
      S_ASSERT: begin
        if (ack_ok) begin
          state_d = S_IDLE;
          count_d = (&count_q) ? count_q : count_q + 32'd1;
        end
`ifdef PERTURB_IRQ_TIMEOUT_EN
        else if (wdog_q == 32'(ACK_TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      mode_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      count_q    <= '0;
      pc_armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      mode_q     <= mode_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      pc_armed_q <= pc_armed_d;
    end
  end
`ifdef PERTURB_IRQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_perturbation_irq_ctrl.sv
// tb_perturbation_irq_ctrl: directed checks of the irq scheduler, with an LFSR reference for RANDOM mode.
module tb_perturbation_irq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] mode, pc, trig_addr;
  logic        pc_valid, sw_valid, ack;
  logic [4:0]  trig_id, sw_id, ack_id;
  logic [7:0]  sw_delay;
  logic        sw_ready, irq, busy, tmo;
  logic [4:0]  irq_id;
  logic [31:0] irq_count;
  logic [31:0] m_lfsr, lfsr_snap, exp_count;
  logic [7:0]  exp_d;
  logic [4:0]  exp_id;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  perturbation_irq_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .pc_i(pc), .pc_valid_i(pc_valid),
    .pc_trig_addr_i(trig_addr), .pc_trig_id_i(trig_id), .sw_req_valid_i(sw_valid),
    .sw_req_ready_o(sw_ready), .sw_req_id_i(sw_id), .sw_req_delay_i(sw_delay),
    .irq_o(irq), .irq_id_o(irq_id), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .busy_o(busy), .irq_count_o(irq_count), .timeout_o(tmo)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 32'h1;
    else m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_ack(input logic [4:0] id);
    ack = 1'b1;
    ack_id = id;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int n, hi, tp, seen;
    mode = 0; pc = 0; trig_addr = 0; pc_valid = 0; sw_valid = 0; ack = 0;
    trig_id = 0; sw_id = 0; ack_id = 0; sw_delay = 0; exp_count = 0;
    repeat (3) step();
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_ready", 32'(sw_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", irq_count, 0);
    chk("rst_timeout", 32'(tmo), 0);
    rst_n = 1'b1;
    mode = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("std_state", {29'd0, irq, sw_ready, busy}, 0);
      chk("std_count", irq_count, 0);
    end
    mode = 0; step();
    chk("mode0_idle", {30'd0, busy, sw_ready}, 0);
    mode = 7; step();
    chk("mode7_idle", {30'd0, busy, sw_ready}, 0);

    mode = 4; #1;
    chk("sw_ready", 32'(sw_ready), 1);
    sw_valid = 1; sw_id = 5; sw_delay = 3;
    step();
    sw_valid = 0;
    chk("sw_wait", {29'd0, busy, sw_ready, irq}, 32'b100);
    repeat (3) step();
    chk("sw_pre_irq", 32'(irq), 0);
    step();
    chk("sw_irq", 32'(irq), 1);
    chk("sw_id", 32'(irq_id), 5);
    do_ack(4);
    chk("wrong_ack_irq", 32'(irq), 1);
    chk("wrong_ack_cnt", irq_count, 0);
    mode = 1; step();
    chk("assert_mode_chg", 32'(irq), 1);
    do_ack(5); exp_count++;
    chk("ack_irq", 32'(irq), 0);
    chk("ack_cnt", irq_count, exp_count);
    do_ack(5);
    chk("idle_ack_cnt", irq_count, exp_count);
    mode = 4; sw_valid = 1; sw_id = 9; sw_delay = 0;
    step();
    sw_valid = 0;
    chk("d0_load", 32'(irq), 0);
    step();
    chk("d0_irq", {26'd0, irq, irq_id}, {26'd0, 1'b1, 5'd9});
    do_ack(9); exp_count++;
    chk("d0_cnt", irq_count, exp_count);

    mode = 3; trig_addr = 32'h1C00_0080; trig_id = 7;
    pc_valid = 1; pc = 32'h1C00_0080;
    step();
    chk("pc_irq", {26'd0, irq, irq_id}, {26'd0, 1'b1, 5'd7});
    step();
    chk("pc_hold", 32'(irq), 1);
    do_ack(7); exp_count++;
    chk("pc_ack", 32'(irq), 0);
    chk("pc_cnt1", irq_count, exp_count);
    seen = 0;
    repeat (3) begin step(); seen += int'(irq); end
    chk("pc_no_retrig", 32'(seen), 0);
    pc = 32'h1C00_0084; step();
    pc = 32'h1C00_0080; step();
    chk("pc_retrig", 32'(irq), 1);
    do_ack(7); exp_count++;
    chk("pc_cnt2", irq_count, exp_count);
    pc_valid = 0;

    mode = 4; sw_valid = 1; sw_id = 3; sw_delay = 200;
    step();
    sw_valid = 0;
    repeat (5) step();
    mode = 2; step();
    chk("abort_idle", {30'd0, busy, irq}, 0);
    mode = 1;
    seen = 0;
    repeat (210) begin step(); seen += int'(irq); end
    chk("abort_no_irq", 32'(seen), 0);
    chk("abort_cnt", irq_count, exp_count);

    mode = 2;
    for (int k = 0; k < 50; k++) begin
      lfsr_snap = m_lfsr;
      exp_d = (lfsr_snap[7:0] < 8'd4) ? 8'd4 : lfsr_snap[7:0];
      exp_id = (lfsr_snap[20:16] < 5'd16) ? 5'd16 : lfsr_snap[20:16];
      step();
      n = 0;
      while (!irq && n < 300) begin step(); n++; end
      chk("rand_delay", 32'(n), 32'(exp_d) + 1);
      chk("rand_id", 32'(irq_id), 32'(exp_id));
      chk("rand_range", 32'(irq_id >= 5'd16), 1);
      do_ack(exp_id); exp_count++;
    end
    mode = 1;
    chk("rand_cnt", irq_count, exp_count);

`ifdef PERTURB_IRQ_TIMEOUT_EN
    mode = 4; sw_valid = 1; sw_id = 2; sw_delay = 0;
    step();
    sw_valid = 0;
    step();
    hi = int'(irq); tp = 0;
    repeat (30) begin step(); hi += int'(irq); tp += int'(tmo); end
    chk("wd_hi_cycles", 32'(hi), 16);
    chk("wd_pulses", 32'(tp), 1);
    chk("wd_cnt", irq_count, exp_count);
`else
    hi = 0; tp = 0;
`endif

    mode = 4; sw_valid = 1; sw_id = 6; sw_delay = 0;
    step();
    sw_valid = 0;
    step();
    chk("pre_rst_irq", 32'(irq), 1);
    chk("no_timeout", 32'(tmo), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 0);
    chk("arst_state", {31'd0, busy}, 0);
    chk("arst_cnt", irq_count, 0);
    step();
    mode = 1;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {30'd0, busy, irq}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
